// File: rtl/c3lib_cfgcsr_fastslow_pulse_arb_if.sv
// c3lib_cfgcsr_fastslow_pulse_arb_if: requester/status bundle for the fast->slow pulse arbiter
interface c3lib_cfgcsr_fastslow_pulse_arb_if #(
  parameter int NREQ = 4
) ();
  localparam int IDW = $clog2(NREQ);
  logic enable;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] pend;
  logic fastpulse;
  logic [IDW-1:0] gnt_id;
  logic [NREQ-1:0] gnt_onehot;
  logic busy;
  logic [NREQ-1:0] drop;
  modport master (
    output enable, req,
    input pend, fastpulse, gnt_id, gnt_onehot, busy, drop
  );
  modport slave (
    input enable, req,
    output pend, fastpulse, gnt_id, gnt_onehot, busy, drop
  );
endinterface

// File: rtl/c3lib_cfgcsr_fastslow_pulse_arb.sv
// c3lib_cfgcsr_fastslow_pulse_arb: round-robin sharing of one fast->slow pulse crossing with ID hold-off
module c3lib_cfgcsr_fastslow_pulse_arb #(
  parameter int NREQ = 4,
  parameter int HOLDOFF = 16
) (
  input logic i_fastclk,
  input logic i_fastrstn,
  c3lib_cfgcsr_fastslow_pulse_arb_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW = $clog2(HOLDOFF + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  state_t state, state_nx;
  logic [NREQ-1:0] pend, clr, drop;
  logic [IDW-1:0] rr_ptr, gnt_id, winner, idx;
  logic [CW-1:0] cnt, cnt_nx;
  logic found, grant, fastpulse;
  // first pending requester at or after rr_ptr, wrapping
  always_comb begin
    winner = rr_ptr;
    idx = rr_ptr;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(rr_ptr) + i) % NREQ);
      if (!found && pend[idx]) begin
        winner = idx;
        found = 1'b1;
      end
    end
  end
  assign grant = (state == IDLE) && bus.enable && (|pend);
  assign clr = grant ? NREQ'(1) << winner : '0;
  // next state and hold-off counter
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      IDLE: state_nx = grant ? ISSUE : IDLE;
      ISSUE: begin
        state_nx = HOLD;
        cnt_nx = CW'(HOLDOFF - 1);
      end
      HOLD: begin
        state_nx = (cnt == '0) ? IDLE : HOLD;
        cnt_nx = (cnt == '0) ? cnt : cnt - CW'(1);
      end
      default: state_nx = IDLE;
    endcase
  end
  // state, pending capture, grant registers; reset drops all pending work
  always_ff @(posedge i_fastclk or negedge i_fastrstn) begin
    if (!i_fastrstn) begin
      state <= IDLE;
      cnt <= '0;
      pend <= '0;
      drop <= '0;
      rr_ptr <= '0;
      gnt_id <= '0;
      fastpulse <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      pend <= bus.req | (pend & ~clr);
      drop <= bus.req & pend & ~clr;
      fastpulse <= grant;
      if (grant) begin
        gnt_id <= winner;
        rr_ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
      end
    end
  end
  assign bus.pend = pend;
  assign bus.drop = drop;
  assign bus.fastpulse = fastpulse;
  assign bus.gnt_id = gnt_id;
  assign bus.busy = (state != IDLE);
  assign bus.gnt_onehot = (state != IDLE) ? NREQ'(1) << gnt_id : '0;
endmodule

// File: tb/tb_c3lib_cfgcsr_fastslow_pulse_arb.sv
// tb_c3lib_cfgcsr_fastslow_pulse_arb: vectors, corner sequences and random run against a timing model
module tb_c3lib_cfgcsr_fastslow_pulse_arb;
  localparam int N = 4;
  localparam int H = 16;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;
  c3lib_cfgcsr_fastslow_pulse_arb_if #(.NREQ(N)) bus ();
  c3lib_cfgcsr_fastslow_pulse_arb #(.NREQ(N), .HOLDOFF(H)) dut (
    .i_fastclk(clk),
    .i_fastrstn(rstn),
    .bus(bus)
  );
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [3:0] req;
    logic en;
    int skip;
    logic [3:0] pend;
    logic pulse;
    logic [1:0] gid;
    logic [3:0] oh;
    logic busy;
    logic [3:0] drop;
  } vec_t;
  vec_t tv[13];
  int m_age, m_rr, m_gid;
  logic [3:0] m_pend, m_drop;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic chk_all(string n, logic [3:0] p, logic fp, logic [1:0] g, logic [3:0] oh, logic b, logic [3:0] d);
    chk({n, ".pend"}, 32'(bus.pend), 32'(p));
    chk({n, ".pulse"}, 32'(bus.fastpulse), 32'(fp));
    chk({n, ".gid"}, 32'(bus.gnt_id), 32'(g));
    chk({n, ".onehot"}, 32'(bus.gnt_onehot), 32'(oh));
    chk({n, ".busy"}, 32'(bus.busy), 32'(b));
    chk({n, ".drop"}, 32'(bus.drop), 32'(d));
  endtask
  task automatic cyc(logic [3:0] r, logic e);
    bus.req = r;
    bus.enable = e;
    @(negedge clk);
  endtask
  task automatic wait_idle();
    int c = 0;
    while ((bus.busy || bus.pend != 4'b0) && c < 200) begin
      cyc(4'b0, 1'b1);
      c++;
    end
    chk("wait_idle", 32'(bus.busy), 32'd0);
  endtask
  task automatic model_reset();
    m_age = H + 1;
    m_rr = 0;
    m_gid = 0;
    m_pend = 4'b0;
    m_drop = 4'b0;
  endtask
  task automatic model_step(logic [3:0] req, logic en);
    logic [3:0] clr;
    logic found;
    clr = 4'b0;
    found = 1'b0;
    if (m_age > H && en && m_pend != 4'b0) begin
      for (int i = 0; i < N; i++) begin
        if (!found && m_pend[(m_rr + i) % N]) begin
          found = 1'b1;
          m_gid = (m_rr + i) % N;
        end
      end
      clr[m_gid] = 1'b1;
      m_rr = (m_gid + 1) % N;
      m_age = 0;
    end else if (m_age <= H) m_age++;
    m_drop = req & m_pend & ~clr;
    m_pend = req | (m_pend & ~clr);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int np, pc[$], pg[$], ng, drops;
    int grants[4];
    logic [3:0] re, r;
    logic e, mb;
    tv[0]  = '{4'b0100, 1'b1, 0,  4'b0100, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000};
    tv[1]  = '{4'b0000, 1'b1, 0,  4'b0000, 1'b1, 2'd2, 4'b0100, 1'b1, 4'b0000};
    tv[2]  = '{4'b0000, 1'b1, 0,  4'b0000, 1'b0, 2'd2, 4'b0100, 1'b1, 4'b0000};
    tv[3]  = '{4'b0000, 1'b1, 14, 4'b0000, 1'b0, 2'd2, 4'b0100, 1'b1, 4'b0000};
    tv[4]  = '{4'b0000, 1'b1, 0,  4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000};
    tv[5]  = '{4'b0010, 1'b0, 0,  4'b0010, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000};
    tv[6]  = '{4'b0010, 1'b0, 0,  4'b0010, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0010};
    tv[7]  = '{4'b0000, 1'b0, 0,  4'b0010, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000};
    tv[8]  = '{4'b0000, 1'b1, 0,  4'b0000, 1'b1, 2'd1, 4'b0010, 1'b1, 4'b0000};
    tv[9]  = '{4'b0000, 1'b1, 16, 4'b0000, 1'b0, 2'd1, 4'b0000, 1'b0, 4'b0000};
    tv[10] = '{4'b0001, 1'b0, 0,  4'b0001, 1'b0, 2'd1, 4'b0000, 1'b0, 4'b0000};
    tv[11] = '{4'b0000, 1'b0, 48, 4'b0001, 1'b0, 2'd1, 4'b0000, 1'b0, 4'b0000};
    tv[12] = '{4'b0000, 1'b1, 0,  4'b0000, 1'b1, 2'd0, 4'b0001, 1'b1, 4'b0000};
    rstn = 1'b0;
    bus.req = 4'b0;
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    chk_all("reset", 4'b0, 1'b0, 2'd0, 4'b0, 1'b0, 4'b0);
    rstn = 1'b1;
    foreach (tv[i]) begin
      cyc(tv[i].req, tv[i].en);
      repeat (tv[i].skip) cyc(4'b0, tv[i].en);
      chk_all($sformatf("vec%0d", i), tv[i].pend, tv[i].pulse, tv[i].gid, tv[i].oh, tv[i].busy, tv[i].drop);
    end
    repeat (3) cyc(4'b0, 1'b1);
    cyc(4'b0001, 1'b1);
    chk("rst_pre_busy", 32'(bus.busy), 32'd1);
    #2 rstn = 1'b0;
    #1 chk_all("rst_async", 4'b0, 1'b0, 2'd0, 4'b0, 1'b0, 4'b0);
    bus.req = 4'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    np = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(4'b0, 1'b1);
      if (bus.fastpulse) np++;
    end
    chk("rst_no_pulse", 32'(np), 32'd0);
    cyc(4'b1011, 1'b1);
    for (int i = 2; i <= 60; i++) begin
      cyc(4'b0, 1'b1);
      if (bus.fastpulse) begin
        pc.push_back(i);
        pg.push_back(int'(bus.gnt_id));
      end
    end
    chk("sim_count", 32'(pc.size()), 32'd3);
    if (pc.size() == 3) begin
      chk("sim_t0", 32'(pc[0]), 32'd2);
      chk("sim_t1", 32'(pc[1]), 32'd20);
      chk("sim_t2", 32'(pc[2]), 32'd38);
      chk("sim_id0", 32'(pg[0]), 32'd0);
      chk("sim_id1", 32'(pg[1]), 32'd1);
      chk("sim_id2", 32'(pg[2]), 32'd3);
    end
    wait_idle();
    cyc(4'b0101, 1'b1);
    ng = 0;
    re = 4'b0;
    for (int c = 0; c < 200 && ng < 4; c++) begin
      cyc(re, 1'b1);
      re = 4'b0;
      if (bus.fastpulse) begin
        grants[ng] = int'(bus.gnt_id);
        ng++;
        re = 4'b1 << bus.gnt_id;
      end
    end
    chk("fair_count", 32'(ng), 32'd4);
    if (ng == 4) begin
      chk("fair_g0", 32'(grants[0]), 32'd0);
      chk("fair_g1", 32'(grants[1]), 32'd2);
      chk("fair_g2", 32'(grants[2]), 32'd0);
      chk("fair_g3", 32'(grants[3]), 32'd2);
    end
    wait_idle();
    cyc(4'b0010, 1'b1);
    chk("same_pend", 32'(bus.pend), 32'h2);
    cyc(4'b0010, 1'b1);
    chk_all("same_grant", 4'b0010, 1'b1, 2'd1, 4'b0010, 1'b1, 4'b0);
    np = 0;
    drops = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(4'b0, 1'b1);
      if (bus.fastpulse) begin
        np++;
        chk("same_id2", 32'(bus.gnt_id), 32'd1);
      end
      if (bus.drop != 4'b0) drops++;
    end
    chk("same_second_pulse", 32'(np), 32'd1);
    chk("same_no_drop", 32'(drops), 32'd0);
    chk("same_pend_clear", 32'(bus.pend), 32'd0);
    rstn = 1'b0;
    bus.req = 4'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) r[k] = ($urandom_range(0, 5) == 0);
      e = ($urandom_range(0, 4) != 0);
      model_step(r, e);
      cyc(r, e);
      mb = (m_age <= H);
      chk_all("rnd", m_pend, m_age == 0, 2'(m_gid), mb ? 4'(1 << m_gid) : 4'b0, mb, m_drop);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
